// File: rtl/mem_wb_stage_pkg.sv
// Shared definitions for the memory-access stage:
// funct3 access codes, MEM FSM states, byte-enable width.
package mem_wb_stage_pkg;

  localparam int BE_W = 4;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [0:0] {
    MEM_IDLE = 1'b0,
    MEM_WAIT = 1'b1
  } mem_state_e;

endpackage

// File: rtl/mem_wb_stage_if.sv
// Data-memory request/ready bus.
// master: stage side (req/we/addr/wdata out); slave: memory side.
interface mem_wb_stage_if
  import mem_wb_stage_pkg::*;
#(
  parameter int ADDR_BITS = 32,
  parameter int DATA_BITS = 32
);

  logic                 dm_req;
  logic [BE_W-1:0]      dm_we;
  logic [ADDR_BITS-1:0] dm_addr;
  logic [DATA_BITS-1:0] dm_wdata;
  logic [DATA_BITS-1:0] dm_rdata;
  logic                 dm_ready;

  modport master (
    output dm_req,
    output dm_we,
    output dm_addr,
    output dm_wdata,
    input  dm_rdata,
    input  dm_ready
  );

  modport slave (
    input  dm_req,
    input  dm_we,
    input  dm_addr,
    input  dm_wdata,
    output dm_rdata,
    output dm_ready
  );

endinterface

// File: rtl/mem_wb_stage_load_align.sv
// Load extraction: picks byte/half/word from a read word by
// address offset and funct3, sign- or zero-extends it.
module load_align
  import mem_wb_stage_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [7:0]  b;
  logic [15:0] h;

  assign b = rdata[{off, 3'b000} +: 8];
  assign h = off[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    data = '0;
    case (funct3)
      F3_LB:   data = {{24{b[7]}}, b};
      F3_LBU:  data = {24'b0, b};
      F3_LH:   data = {{16{h[15]}}, h};
      F3_LHU:  data = {16'b0, h};
      F3_LW:   data = rdata;
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// Memory-access stage and MEM/WB register: drives the dm bus,
// stalls on !dm_ready, registers RegWrite/rd/wb_data.
module mem_wb_stage
  import mem_wb_stage_pkg::*;
#(
  parameter int ADDR_BITS = 32,
  parameter int DATA_BITS = 32,
  parameter int REG_ADDR  = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 EXEMEM_RDSrc,
  input  logic                 EXEMEM_MemtoReg,
  input  logic                 EXEMEM_MemRead,
  input  logic                 EXEMEM_MemWrite,
  input  logic                 EXEMEM_RegWrite,
  input  logic [ADDR_BITS-1:0] EXEMEM_pc_to_reg,
  input  logic [DATA_BITS-1:0] EXEMEM_ALU_out,
  input  logic [DATA_BITS-1:0] EXEMEM_rs2_data,
  input  logic [REG_ADDR-1:0]  EXEMEM_rd_addr,
  input  logic [2:0]           EXEMEM_funct3,
  mem_wb_stage_if.master       dm,
  output logic                 mem_stall,
  output logic                 MEMWB_RegWrite,
  output logic [REG_ADDR-1:0]  MEMWB_rd_addr,
  output logic [DATA_BITS-1:0] MEMWB_wb_data
);

  mem_state_e           state;
  mem_state_e           state_nx;
  logic                 access;
  logic [1:0]           off;
  logic [BE_W-1:0]      we;
  logic [DATA_BITS-1:0] wdata;
  logic [DATA_BITS-1:0] ld_data;
  logic [DATA_BITS-1:0] wb_sel;

  assign access = EXEMEM_MemRead | EXEMEM_MemWrite;
  assign off    = EXEMEM_ALU_out[1:0];

  assign dm.dm_req   = access;
  assign dm.dm_addr  = {EXEMEM_ALU_out[ADDR_BITS-1:2], 2'b00};
  assign dm.dm_we    = we;
  assign dm.dm_wdata = wdata;

  assign mem_stall = access & ~dm.dm_ready;

  always_comb begin
    we    = '0;
    wdata = EXEMEM_rs2_data;
    case (EXEMEM_funct3)
      F3_SB: begin
        we    = 4'b0001 << off;
        wdata = {4{EXEMEM_rs2_data[7:0]}};
      end
      F3_SH: begin
        we    = 4'b0011 << {off[1], 1'b0};
        wdata = {2{EXEMEM_rs2_data[15:0]}};
      end
      F3_SW:   we = 4'b1111;
      default: we = '0;
    endcase
    if (!EXEMEM_MemWrite) we = '0;
  end

  load_align u_load_align (
    .rdata  (dm.dm_rdata),
    .off    (off),
    .funct3 (EXEMEM_funct3),
    .data   (ld_data)
  );

  always_comb begin
    wb_sel = EXEMEM_RDSrc ? EXEMEM_pc_to_reg : EXEMEM_ALU_out;
    if (EXEMEM_MemtoReg) wb_sel = ld_data;
  end

  // state only tracks an outstanding access; stall itself is
  // combinational so a ready-first access costs no extra cycle
  always_comb begin
    state_nx = state;
    case (state)
      MEM_IDLE: if (mem_stall) state_nx = MEM_WAIT;
      MEM_WAIT: if (!mem_stall) state_nx = MEM_IDLE;
      default:  state_nx = MEM_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= MEM_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // a stalled cycle writes a bubble; rd/data hold so the
  // forwarding source stays at the last completed value
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      MEMWB_RegWrite <= 1'b0;
      MEMWB_rd_addr  <= '0;
      MEMWB_wb_data  <= '0;
    end else if (mem_stall) begin
      MEMWB_RegWrite <= 1'b0;
    end else begin
      MEMWB_RegWrite <= EXEMEM_RegWrite;
      MEMWB_rd_addr  <= EXEMEM_rd_addr;
      MEMWB_wb_data  <= wb_sel;
    end
  end

`ifndef SYNTHESIS
  a_wait_stable: assert property (
    @(posedge clk) disable iff (!rst)
    (state == MEM_WAIT) |->
      ($stable(dm.dm_addr) && $stable(dm.dm_we) &&
       $stable(dm.dm_wdata))
  );
`endif

endmodule
